// File: rtl/dma_desc_seq.sv
// dma_desc_seq: walks the latched descriptor-enable mask, issuing one slice request per
// enabled descriptor, then drains outstanding AXI traffic before signalling completion.
module dma_desc_seq #(
  parameter int DMA_NUM_DESC   = 8,
  parameter int DESC_IDX_WIDTH = $clog2(DMA_NUM_DESC),
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      csr_dma_start,
  input  logic                      csr_dma_abort,
  input  logic                      csr_dma_loop,
  input  logic [DMA_NUM_DESC-1:0]   csr_desc_en,
  output logic [DESC_IDX_WIDTH-1:0] dma_slice_idx,
  output logic                      dma_slice_valid,
  input  logic                      dma_slice_done,
  input  logic                      dma_axi_idle,
  output logic                      dma_busy,
  output logic                      dma_done,
  output logic                      dma_aborted,
  output logic [CNT_WIDTH-1:0]      dma_slice_cnt
);
  typedef enum logic [2:0] {IDLE, SCAN, ISSUE, WAIT, DRAIN} state_t;
  localparam logic [DESC_IDX_WIDTH-1:0] LAST = DESC_IDX_WIDTH'(DMA_NUM_DESC - 1);
  state_t                    state;
  logic [DESC_IDX_WIDTH-1:0] scan_idx;
  logic [DMA_NUM_DESC-1:0]   en_q;
  logic                      loop_q;
  logic                      abort_pend;
  logic                      pass_issued;
  logic                      abort_any;
  logic                      is_last;
  assign abort_any = csr_dma_abort | abort_pend;
  assign is_last   = scan_idx == LAST;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      scan_idx        <= '0;
      en_q            <= '0;
      loop_q          <= 1'b0;
      abort_pend      <= 1'b0;
      pass_issued     <= 1'b0;
      dma_slice_idx   <= '0;
      dma_slice_valid <= 1'b0;
      dma_busy        <= 1'b0;
      dma_done        <= 1'b0;
      dma_aborted     <= 1'b0;
      dma_slice_cnt   <= '0;
    end else begin
      dma_slice_valid <= 1'b0;
      dma_done        <= 1'b0;
      case (state)
        IDLE: if (csr_dma_start) begin
          en_q          <= csr_desc_en;
          loop_q        <= csr_dma_loop;
          scan_idx      <= '0;
          dma_slice_cnt <= '0;
          dma_aborted   <= 1'b0;
          pass_issued   <= 1'b0;
          dma_busy      <= 1'b1;
          state         <= SCAN;
        end
        SCAN: if (abort_any) begin
          dma_aborted <= 1'b1;
          state       <= DRAIN;
        end else if (en_q[scan_idx]) begin
          dma_slice_valid <= 1'b1;
          dma_slice_idx   <= scan_idx;
          state           <= ISSUE;
        end else if (!is_last) begin
          scan_idx <= scan_idx + 1'b1;
        end else if (loop_q && pass_issued) begin
          // only rewalk when the pass issued something, so an empty mask cannot spin
          scan_idx    <= '0;
          pass_issued <= 1'b0;
        end else begin
          state <= DRAIN;
        end
        ISSUE: begin
          pass_issued <= 1'b1;
          if (csr_dma_abort) abort_pend <= 1'b1;
          state <= WAIT;
        end
        WAIT: if (!dma_slice_done) begin
          if (csr_dma_abort) abort_pend <= 1'b1;
        end else begin
          if (~&dma_slice_cnt) dma_slice_cnt <= dma_slice_cnt + 1'b1;
          if (abort_any) begin
            dma_aborted <= 1'b1;
            state       <= DRAIN;
          end else if (is_last) begin
            scan_idx    <= '0;
            pass_issued <= 1'b0;
            state       <= loop_q ? SCAN : DRAIN;
          end else begin
            scan_idx <= scan_idx + 1'b1;
            state    <= SCAN;
          end
        end
        DRAIN: if (dma_axi_idle) begin
          dma_busy   <= 1'b0;
          dma_done   <= 1'b1;
          abort_pend <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dma_desc_seq.sv
// tb_dma_desc_seq: directed and randomized runs against a mask-walk reference model with
// a responding slice engine; counter width is reduced so saturation is reachable.
module tb_dma_desc_seq;
  localparam int N  = 8;
  localparam int IW = 3;
  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          csr_dma_start = 1'b0;
  logic          csr_dma_abort = 1'b0;
  logic          csr_dma_loop = 1'b0;
  logic [N-1:0]  csr_desc_en = '0;
  logic [IW-1:0] dma_slice_idx;
  logic          dma_slice_valid;
  logic          dma_slice_done = 1'b0;
  logic          dma_axi_idle = 1'b1;
  logic          dma_busy;
  logic          dma_done;
  logic          dma_aborted;
  logic [CW-1:0] dma_slice_cnt;
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int vq_idx[$];
  int vq_cyc[$];
  int dq_cyc[$];
  int done_cnt = 0;
  int done_cyc = 0;
  logic busy_at_done = 1'b0;
  int done_dly = 5;
  int wc = -1;

  dma_desc_seq #(.DMA_NUM_DESC(N), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .csr_dma_start(csr_dma_start), .csr_dma_abort(csr_dma_abort),
    .csr_dma_loop(csr_dma_loop), .csr_desc_en(csr_desc_en), .dma_slice_idx(dma_slice_idx),
    .dma_slice_valid(dma_slice_valid), .dma_slice_done(dma_slice_done),
    .dma_axi_idle(dma_axi_idle), .dma_busy(dma_busy), .dma_done(dma_done),
    .dma_aborted(dma_aborted), .dma_slice_cnt(dma_slice_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(negedge clk);
    if (rst_n && dma_slice_valid) begin
      vq_idx.push_back(int'(dma_slice_idx));
      vq_cyc.push_back(cyc);
    end
    if (dma_done) begin
      done_cnt++;
      done_cyc = cyc;
      busy_at_done = dma_busy;
    end
  end

  // slice engine: done pulse done_dly cycles after each request
  initial forever begin
    @(negedge clk);
    dma_slice_done = 1'b0;
    if (!rst_n) wc = -1;
    else if (dma_slice_valid) wc = done_dly;
    else if (wc > 0) begin
      wc--;
      if (wc == 0) begin
        dma_slice_done = 1'b1;
        dq_cyc.push_back(cyc);
        wc = -1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_start(input string tag, input logic [N-1:0] m, input logic lp, input logic ab, output int s);
    vq_idx.delete(); vq_cyc.delete(); dq_cyc.delete(); done_cnt = 0;
    csr_desc_en = m; csr_dma_loop = lp; csr_dma_start = 1'b1; csr_dma_abort = ab;
    step(1);
    csr_dma_start = 1'b0; csr_dma_abort = 1'b0;
    s = cyc;
    chk({tag, " busy_after_start"}, dma_busy, 1);
    chk({tag, " aborted_cleared"}, dma_aborted, 0);
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    while (done_cnt == 0 && t < 3000) begin
      step(1);
      t++;
    end
    step(3);
    chk({tag, " done_pulses"}, done_cnt, 1);
    chk({tag, " busy_low_at_done"}, busy_at_done, 0);
  endtask

  // every valid must follow the cyclic order of enabled indices, spaced by the scan distance
  task automatic check_walk(input string tag, input logic [N-1:0] m, input int s);
    int e[$];
    int prev = 0;
    for (int i = 0; i < N; i++) if (m[i]) e.push_back(i);
    if (e.size() == 0) begin
      chk({tag, " no_valid"}, vq_idx.size(), 0);
      return;
    end
    for (int k = 0; k < vq_idx.size(); k++) begin
      int j = e[k % e.size()];
      chk({tag, " idx"}, vq_idx[k], j);
      if (k == 0) chk({tag, " first_lat"}, vq_cyc[0], s + 1 + j);
      else if (k - 1 < dq_cyc.size()) chk({tag, " gap"}, vq_cyc[k], dq_cyc[k-1] + 2 + ((j - prev - 1 + N) % N));
      prev = j;
    end
  endtask

  task automatic run_norm(input string tag, input logic [N-1:0] m, input logic lp, input logic ab, input logic mess, input int dly);
    int s, n, last, exp_done;
    done_dly = dly;
    do_start(tag, m, lp, ab, s);
    if (mess) begin
      step(1);
      csr_desc_en = ~m; csr_dma_loop = ~lp; csr_dma_start = 1'b1;
      step(1);
      csr_dma_start = 1'b0;
    end
    wait_done(tag);
    check_walk(tag, m, s);
    n = $countones(m);
    last = 0;
    for (int i = 0; i < N; i++) if (m[i]) last = i;
    chk({tag, " n_valid"}, vq_idx.size(), n);
    chk({tag, " n_slice_done"}, dq_cyc.size(), n);
    exp_done = (n == 0) ? s + 1 + N : ((dq_cyc.size() == n) ? dq_cyc[n-1] + 2 + (N - 1 - last) : -1);
    chk({tag, " done_cycle"}, done_cyc, exp_done);
    chk({tag, " cnt"}, dma_slice_cnt, (n > SAT) ? SAT : n);
    chk({tag, " aborted"}, dma_aborted, 0);
    chk({tag, " busy_idle"}, dma_busy, 0);
  endtask

  task automatic run_abort(input string tag, input logic [N-1:0] m, input int k, input int extra, input int dly, output int nv);
    int s, a, late, t;
    done_dly = dly;
    do_start(tag, m, 1'b1, 1'b0, s);
    t = 0;
    while (vq_idx.size() < k && t < 3000) begin
      step(1);
      t++;
    end
    chk({tag, " reached_k"}, vq_idx.size() >= k, 1);
    step(extra);
    csr_dma_abort = 1'b1;
    a = cyc;
    step(1);
    csr_dma_abort = 1'b0;
    wait_done(tag);
    check_walk(tag, m, s);
    late = 0;
    foreach (vq_cyc[i]) if (vq_cyc[i] > a) late++;
    nv = vq_idx.size();
    chk({tag, " valid_after_abort"}, late, 0);
    chk({tag, " all_slices_done"}, dq_cyc.size(), nv);
    chk({tag, " cnt"}, dma_slice_cnt, (nv > SAT) ? SAT : nv);
    chk({tag, " aborted"}, dma_aborted, 1);
  endtask

  initial begin
    int s, r, nv, t;
    step(2);
    chk("reset_outs", {dma_slice_idx, dma_slice_valid, dma_busy, dma_done, dma_aborted, dma_slice_cnt}, 0);
    rst_n = 1'b1;
    step(2);
    run_norm("en05", 8'h05, 1'b0, 1'b0, 1'b0, 5);
    run_norm("en80", 8'h80, 1'b0, 1'b0, 1'b0, 5);
    run_abort("loop03_abort", 8'h03, 2, 1, 5, nv);
    chk("loop03_abort nv", nv, 2);
    run_norm("after_abort", 8'h01, 1'b0, 1'b0, 1'b0, 2);
    run_abort("sat", 8'hFF, 18, 0, 1, nv);
    run_norm("empty_loop", 8'h00, 1'b1, 1'b0, 1'b0, 3);
    run_norm("start_abort", 8'h05, 1'b0, 1'b1, 1'b0, 3);
    run_norm("start_busy", 8'h06, 1'b0, 1'b0, 1'b1, 4);
    // DRAIN must hold until the AXI side reports idle
    dma_axi_idle = 1'b0;
    done_dly = 3;
    do_start("drain", 8'h01, 1'b0, 1'b0, s);
    t = 0;
    while (dq_cyc.size() < 1 && t < 200) begin
      step(1);
      t++;
    end
    step(20);
    chk("drain busy_held", dma_busy, 1);
    chk("drain no_done", done_cnt, 0);
    dma_axi_idle = 1'b1;
    r = cyc;
    wait_done("drain");
    chk("drain done_cycle", done_cyc, r + 1);
    chk("drain cnt", dma_slice_cnt, 1);
    // reset while a slice is outstanding
    done_dly = 10;
    do_start("rst_mid", 8'h01, 1'b0, 1'b0, s);
    t = 0;
    while (vq_idx.size() < 1 && t < 200) begin
      step(1);
      t++;
    end
    step(2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid outs", {dma_slice_idx, dma_slice_valid, dma_busy, dma_done, dma_aborted, dma_slice_cnt}, 0);
    step(2);
    rst_n = 1'b1;
    step(1);
    run_norm("post_rst", 8'h01, 1'b0, 1'b0, 1'b0, 2);
    for (int it = 0; it < 8; it++)
      run_norm("rand_norm", N'($urandom), 1'b0, 1'b0, 1'b0, $urandom_range(1, 6));
    for (int it = 0; it < 5; it++)
      run_abort("rand_abort", N'($urandom_range(1, 255)), $urandom_range(1, 20), $urandom_range(0, 6), $urandom_range(1, 6), nv);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dma_desc_seq.md
Name: dma_desc_seq

Overview:
Descriptor sequencer sitting directly upstream of the DMA slice engine. On a CSR start it walks the latched descriptor-enable mask in index order. For each enabled descriptor it issues one slice request (index plus a 1-cycle valid) and waits for the slice's done pulse. After the list, it waits for the AXI interface to go idle, then reports completion. It supports loop mode and graceful abort, and provides busy/done/abort status to the CSR block.

Parameters:
DMA_NUM_DESC, 8, number of descriptors; must be >= 2.
DESC_IDX_WIDTH, $clog2(DMA_NUM_DESC), descriptor index width.
CNT_WIDTH, 16, width of the completed-slice counter.

Ports:
clk  input  1  clock
rst_n  input  1  reset; asynchronous, active-low
csr_dma_start  input  1  start pulse; sampled only in IDLE
csr_dma_abort  input  1  abort pulse; sampled in any non-IDLE state
csr_dma_loop  input  1  1 = rewalk list after last descriptor; latched at start
csr_desc_en  input  DMA_NUM_DESC  per-descriptor enable mask; latched at start
dma_slice_idx  output  DESC_IDX_WIDTH  descriptor index presented to the slice engine
dma_slice_valid  output  1  1-cycle slice request
dma_slice_done  input  1  1-cycle pulse from the slice engine; all AXI requests of the slice accepted
dma_axi_idle  input  1  1 = no outstanding AXI transactions
dma_busy  output  1  high from the cycle after start is accepted until return to IDLE
dma_done  output  1  1-cycle completion pulse
dma_aborted  output  1  sticky; last run ended by abort; cleared on next accepted start
dma_slice_cnt  output  CNT_WIDTH  slices completed in the current run; saturating; cleared on start

Behaviour:
- Reset values: all outputs 0. State IDLE; scan_idx, en_q, loop_q, abort_pend, pass_issued all 0.
- States: IDLE, SCAN, ISSUE, WAIT, DRAIN. All outputs are registered.
- IDLE: on csr_dma_start:
  - latch en_q <= csr_desc_en and loop_q <= csr_dma_loop;
  - scan_idx <= 0; clear dma_slice_cnt, dma_aborted, pass_issued;
  - go to SCAN.
  - Abort in IDLE is ignored. Start and abort in the same IDLE cycle: start wins, abort dropped.
- SCAN (one index examined per cycle):
  - abort (or abort_pend) -> DRAIN; set dma_aborted.
  - else if en_q[scan_idx] -> ISSUE.
  - else if scan_idx != DMA_NUM_DESC-1 -> scan_idx+1, stay in SCAN.
  - else (last index, not enabled): if loop_q && pass_issued -> scan_idx <= 0, clear pass_issued, stay in SCAN; otherwise -> DRAIN.
- ISSUE: exactly one cycle. dma_slice_valid = 1, dma_slice_idx = scan_idx; set pass_issued; -> WAIT.
  - dma_slice_idx holds its value from ISSUE through WAIT.
  - Abort here sets abort_pend. The slice cannot be cancelled.
- WAIT: hold until dma_slice_done.
  - Abort in WAIT sets abort_pend.
  - On dma_slice_done: dma_slice_cnt+1, saturating at all-ones. Then:
    - abort_pend (or abort in the same cycle) -> DRAIN, set dma_aborted;
    - else scan_idx == DMA_NUM_DESC-1 -> if loop_q, scan_idx <= 0, clear pass_issued, go to SCAN; else DRAIN;
    - else scan_idx+1 -> SCAN.
  - dma_slice_done outside WAIT is ignored.
- DRAIN: wait for dma_axi_idle == 1. On the edge where it is seen: -> IDLE, dma_busy <= 0, dma_done <= 1 for one cycle; clear abort_pend.
- Min slice-to-slice gap: done (WAIT) -> SCAN -> ISSUE, i.e. valid lands 2 cycles after done. This satisfies the slice engine being back in IDLE.
- Latency: start accepted at edge N; if en[0]=1, dma_slice_valid is high in cycle N+2 (SCAN in N+1).
- Empty mask (all 0): walk all indices, no valid issued, DRAIN, done pulse. dma_slice_cnt = 0. Loop mode does not spin, because pass_issued = 0.
- Start while dma_busy: ignored. csr_desc_en changes during a run have no effect.
- Reset mid-operation: returns immediately to reset values. The slice engine shares rst_n; no request is left pending.

Test Plan:
- en=8'b0000_0101, loop=0, slice done 5 cycles after each valid, axi_idle=1 -> valid with idx 0 then idx 2, none for others. dma_done pulses once; dma_slice_cnt=2; dma_aborted=0; dma_busy low in the done cycle.
- en=8'h80, start at edge N -> SCAN for 8 cycles; valid with idx=7 in cycle N+9; after done, DRAIN -> done pulse; cnt=1.
- en=8'b0000_0011, loop=1, abort pulsed while idx 1 is in WAIT -> slice 1 still completes; no further valid; DRAIN; dma_aborted=1; cnt = 2 x passes completed + ... (exact count checked by scoreboard); next start clears dma_aborted.
- en=8'h01, axi_idle held 0 for 20 cycles after slice done -> state DRAIN, dma_busy=1, no dma_done until axi_idle=1; then done pulses exactly one cycle later.
- en=8'h00, loop=1 -> no valid; done after 8 scan cycles plus drain; cnt=0. Start+abort in the same IDLE cycle -> run proceeds normally. Start while busy -> ignored.
- Assert rst_n low during WAIT -> next cycle all outputs 0 and state IDLE. A following start with en=8'h01 runs normally, cnt=1.
